timerm: RTL and testbench

Memory-mapped down-counting timer peripheral on the CPU memory bus, downstream of the CPU's `mbus_aout`/`mbus_dout`/`mbus_wen` outputs. It returns read data combinationally on `dout`, which the bus decoder muxes onto the CPU's `mbus_din`. It provides a 16-bit prescaler, a WIDTH-bit down counter with optional auto-reload, a sticky underflow flag and a level interrupt request. The system address decoder generates `cs`; this block decodes only the low word-offset bits.

---
 rtl/timerm_pkg.sv | 26 ++
 rtl/timerm_prescm.sv | 43 ++++
 rtl/timerm.sv | 147 ++++++++++++++
 tb/tb_timerm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timerm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timerm_pkg
// Description : Shared definitions for the timerm timer peripheral: register
//               word offsets and control/status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package timerm_pkg;

    // Register word offsets (addr[1:0])
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_RELOAD = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STAT   = 2'd3;

    // CTRL bit positions
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_ARL     = 1;
    localparam int CTRL_IEN     = 2;
    localparam int CTRL_PRE_LSB = 8;

    // STAT bit positions
    localparam int STAT_UF = 0;

endpackage
`default_nettype wire

// File: rtl/timerm_prescm.sv
`default_nettype none
// ============================================================================
// Module      : prescm
// Description : Prescaler for timerm. Counts 0..pre while enabled and emits a
//               one-cycle tick when the count equals pre, then wraps to 0.
//               Held at 0 while disabled; clr forces it back to 0.
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               en    - count enable (CTRL.RUN)
//               clr   - synchronous clear
//               pre   - terminal count
//               tick  - one-cycle pulse at terminal count
// Revision    : 1.0 - initial release
// ============================================================================
module prescm #(
    parameter int PRE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PRE_WIDTH-1:0] pre,
    output logic                 tick
);

    localparam logic [PRE_WIDTH-1:0] PRE_ONE = PRE_WIDTH'(1);

    logic [PRE_WIDTH-1:0] cnt;

    assign tick = en & (cnt == pre);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRE_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timerm.sv
`default_nettype none
// ============================================================================
// Module      : timerm
// Description : Memory-mapped down-counting timer with prescaler, optional
//               auto-reload, sticky underflow flag and level interrupt.
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               cs    - chip select from system address decoder
//               addr  - register word offset
//               wen   - write strobe
//               din   - write data
//               dout  - combinational read data (0 when cs=0)
//               irq   - interrupt request, UF & IEN
// Revision    : 1.0 - initial release
// ============================================================================
module timerm
    import timerm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PRE_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic [1:0]       addr,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic                 run;
    logic                 arl;
    logic                 ien;
    logic [PRE_WIDTH-1:0] pre;
    logic [WIDTH-1:0]     reload;
    logic [WIDTH-1:0]     count;
    logic                 uf;

    logic wr_ctrl;
    logic wr_reload;
    logic wr_count;
    logic wr_stat;
    logic pre_clr;
    logic tick;
    logic tick_eff;
    logic underflow;

    assign wr_ctrl   = cs & wen & (addr == TMR_CTRL);
    assign wr_reload = cs & wen & (addr == TMR_RELOAD);
    assign wr_count  = cs & wen & (addr == TMR_COUNT);
    assign wr_stat   = cs & wen & (addr == TMR_STAT);

    // Restart the prescale period on a COUNT load or on RUN going 0->1.
    assign pre_clr = wr_count | (wr_ctrl & din[CTRL_RUN] & ~run);

    prescm #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescm (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .clr   (pre_clr),
        .pre   (pre),
        .tick  (tick)
    );

    // A tick is discarded when software loads COUNT or clears RUN on the
    // same edge; the software write takes precedence.
    assign tick_eff  = tick & ~wr_count & ~(wr_ctrl & ~din[CTRL_RUN]);
    assign underflow = tick_eff & (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
            arl <= 1'b0;
            ien <= 1'b0;
            pre <= '0;
        end else if (wr_ctrl) begin
            run <= din[CTRL_RUN];
            arl <= din[CTRL_ARL];
            ien <= din[CTRL_IEN];
            pre <= din[CTRL_PRE_LSB +: PRE_WIDTH];
        end else if (underflow && !arl) begin
            run <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload <= '0;
        end else if (wr_reload) begin
            reload <= din;
        end
    end

    // Auto-reload uses the pre-edge RELOAD value, so a RELOAD write on the
    // same edge only affects the next reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= din;
        end else if (tick_eff) begin
            if (count != '0) begin
                count <= count - CNT_ONE;
            end else if (arl) begin
                count <= reload;
            end
        end
    end

    // Set beats W1C when both land on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uf <= 1'b0;
        end else if (underflow) begin
            uf <= 1'b1;
        end else if (wr_stat && din[STAT_UF]) begin
            uf <= 1'b0;
        end
    end

    assign irq = uf & ien;

    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                TMR_CTRL: begin
                    dout[CTRL_RUN]                  = run;
                    dout[CTRL_ARL]                  = arl;
                    dout[CTRL_IEN]                  = ien;
                    dout[CTRL_PRE_LSB +: PRE_WIDTH] = pre;
                end
                TMR_RELOAD: dout = reload;
                TMR_COUNT:  dout = count;
                TMR_STAT:   dout[STAT_UF] = uf;
                default:    dout = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timerm.sv
`default_nettype none
// ============================================================================
// Module      : tb_timerm
// Description : Self-checking bench for timerm. Directed scenarios plus a
//               randomized bus-traffic phase, all compared against a
//               behavioural model of the register/timer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timerm;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [1:0]  addr;
    logic        wen;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    string phase    = "init";

    // Reference model state
    logic        m_run, m_arl, m_ien, m_uf;
    logic [15:0] m_pre, m_psc;
    logic [31:0] m_reload, m_count;

    logic [31:0] rd;
    logic        ir;

    timerm #(
        .WIDTH     (32),
        .PRE_WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .addr  (addr),
        .wen   (wen),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s [%s] cyc=%0d: got 0x%08h expected 0x%08h", tag, phase, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_arl = 0; m_ien = 0; m_uf = 0;
        m_pre = 0; m_psc = 0; m_reload = 0; m_count = 0;
    endtask

    function automatic logic [31:0] model_read(input logic c, input logic [1:0] a);
        if (!c) return 32'h0;
        case (a)
            2'd0:    return {8'h00, m_pre, 5'h00, m_ien, m_arl, m_run};
            2'd1:    return m_reload;
            2'd2:    return m_count;
            default: return {31'h0, m_uf};
        endcase
    endfunction

    // Advance the model across one rising edge given the bus inputs.
    task automatic model_step(input logic c, input logic [1:0] a, input logic w, input logic [31:0] d);
        logic        wr, tick, counts, unf;
        logic [15:0] n_psc;
        logic [31:0] n_count;
        wr     = c && w;
        tick   = m_run && (m_psc == m_pre);
        counts = tick && !(wr && a == 2'd2) && !(wr && a == 2'd0 && !d[0]);
        unf    = counts && (m_count == 0);

        if (!m_run || tick || (wr && a == 2'd2)) n_psc = 16'd0;
        else                                     n_psc = m_psc + 16'd1;

        n_count = m_count;
        if (wr && a == 2'd2)  n_count = d;
        else if (counts) begin
            if (m_count != 0) n_count = m_count - 1;
            else if (m_arl)   n_count = m_reload;
        end

        if (unf)                        m_uf = 1'b1;
        else if (wr && a == 2'd3 && d[0]) m_uf = 1'b0;

        if (wr && a == 2'd0) begin
            m_run = d[0]; m_arl = d[1]; m_ien = d[2]; m_pre = d[23:8];
        end else if (unf && !m_arl) begin
            m_run = 1'b0;
        end

        if (wr && a == 2'd1) m_reload = d;
        m_count = n_count;
        m_psc   = n_psc;
    endtask

    // One bus cycle: drive at negedge, sample just after, then cross posedge.
    task automatic drive(input logic c, input logic [1:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] r, output logic i);
        @(negedge clk);
        cs = c; addr = a; wen = w; din = d;
        #1;
        r = dout;
        i = irq;
        check_eq("dout", dout, model_read(c, a));
        check_eq("irq", {31'h0, irq}, {31'h0, m_uf & m_ien});
        model_step(c, a, w, d);
        @(posedge clk);
        cyc++;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r; logic i;
        drive(1'b1, a, 1'b1, d, r, i);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        drive(1'b1, a, 1'b0, 32'h0, rd, ir);
    endtask

    initial begin
        int first;
        int period;
        logic found;
        logic c, w;
        logic [1:0] a;
        logic [31:0] d;

        reset = 1'b0; cs = 0; addr = 0; wen = 0; din = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        phase = "reset";
        for (int k = 0; k < 4; k++) begin
            rd_reg(2'(k));
            check_eq("reset_val", rd, 32'h0);
        end

        phase = "ctrl_rb";
        wr_reg(2'd0, 32'hFFFF_FFFF);
        rd_reg(2'd0);
        check_eq("ctrl_readback", rd, 32'h00FF_FF07);
        wr_reg(2'd0, 32'h0);
        wr_reg(2'd3, 32'h1);

        phase = "oneshot";
        wr_reg(2'd2, 32'd3);
        wr_reg(2'd0, 32'h1);
        for (int k = 3; k >= 0; k--) begin
            rd_reg(2'd2);
            check_eq("oneshot_count", rd, 32'(k));
        end
        rd_reg(2'd3);
        check_eq("oneshot_uf", rd, 32'h1);
        rd_reg(2'd0);
        check_eq("oneshot_run", rd, 32'h0);
        rd_reg(2'd2);
        check_eq("oneshot_hold", rd, 32'h0);

        phase = "autoreload";
        wr_reg(2'd1, 32'd4);
        wr_reg(2'd2, 32'd4);
        wr_reg(2'd3, 32'h1);
        wr_reg(2'd0, 32'h0203);
        first = -1; period = 0; found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            rd_reg(2'd3);
            if (rd[0]) begin
                if (first < 0) begin
                    first = cyc;
                    wr_reg(2'd3, 32'h1);
                end else begin
                    period = cyc - first;
                    found  = 1'b1;
                end
            end
        end
        check_eq("arl_found", {31'h0, found}, 32'h1);
        check_eq("arl_period", 32'(period), 32'd15);
        rd_reg(2'd2);
        check_eq("arl_reload", rd, 32'd4);

        phase = "irq";
        wr_reg(2'd3, 32'h1);
        wr_reg(2'd0, 32'h0207);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            rd_reg(2'd3);
            if (ir) found = 1'b1;
        end
        check_eq("irq_found", {31'h0, found}, 32'h1);
        wr_reg(2'd3, 32'h0);
        rd_reg(2'd3);
        check_eq("w1c_zero_irq", {31'h0, ir}, 32'h1);
        wr_reg(2'd3, 32'h1);
        rd_reg(2'd3);
        check_eq("w1c_irq", {31'h0, ir}, 32'h0);
        wr_reg(2'd0, 32'h0);

        phase = "collide";
        wr_reg(2'd2, 32'h0);
        wr_reg(2'd3, 32'h1);
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd3, 32'h1);
        rd_reg(2'd3);
        check_eq("w1c_vs_set", rd, 32'h1);
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd0, 32'h3);
        rd_reg(2'd2);
        wr_reg(2'd2, 32'h10);
        rd_reg(2'd2);
        check_eq("count_wr_tick", rd, 32'h10);
        rd_reg(2'd2);
        wr_reg(2'd0, 32'h2);
        rd_reg(2'd2);
        check_eq("runclr_tick", rd, 32'h0E);

        phase = "decode";
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'(k), 1'b1, 32'hFFFF_FFFF, rd, ir);
            check_eq("cs0_dout", rd, 32'h0);
        end
        for (int k = 0; k < 4; k++) rd_reg(2'(k));

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            c = ($urandom_range(0, 9) != 0);
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            d = $urandom;
            if (a == 2'd0) begin
                if ($urandom_range(0, 7) != 0) d[23:8] = 16'($urandom_range(0, 3));
                d[0] = ($urandom_range(0, 3) != 0);
            end else if (a != 2'd3) begin
                if ($urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 7));
            end
            drive(c, a, w, d, rd, ir);
        end

        phase = "async_reset";
        wr_reg(2'd2, 32'd9);
        wr_reg(2'd0, 32'h7);
        repeat (3) rd_reg(2'd2);
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cs = 1'b1; addr = 2'(k); wen = 1'b0;
            #1;
            check_eq("rst_dout", dout, 32'h0);
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            rd_reg(2'd2);
            check_eq("idle_count", rd, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
